dll_replay_ctrl: RTL and testbench
==================================

Name: dll_replay_ctrl

Overview:
- Parametrised sequence-number and replay controller for the PCIe Data Link Layer transmit path.
- Sits between the TL-facing TLP ingress of the DLL write side and the retry buffer datapath.
- Assigns sequence numbers, tracks outstanding TLPs, and processes Ack/Nak DLLPs decoded by the DLL read side.
- Runs the replay timer, sequences replays, and requests link retrain on REPLAY_NUM rollover.

Parameters:
SEQ_WIDTH, 12, sequence number width; all sequence arithmetic is mod 2^SEQ_WIDTH.
RETRY_DEPTH_LG2, 8, log2 of the maximum number of outstanding TLPs the retry buffer can hold.
TIMER_WIDTH, 16, replay timer width.
REPLAY_TIMEOUT, 711, replay timer expiry in sclk cycles; must be less than 2^TIMER_WIDTH.
REPLAY_NUM_MAX, 3, number of replays allowed before a retrain request.

Ports:
sclk  in  1  clock; every register updates on its rising edge.
srst  in  1  synchronous, active-high reset.
tl_valid_i  in  1  new TLP offered.
tl_ready_o  out  1  new TLP accepted when tl_valid_i and tl_ready_o are both high.
tl_seq_o  out  SEQ_WIDTH  sequence number assigned to the offered TLP; equals next_seq.
acknak_valid_i  in  1  Ack/Nak DLLP strobe; one cycle per DLLP.
acknak_is_nak_i  in  1  1 = Nak, 0 = Ack.
acknak_seq_i  in  SEQ_WIDTH  AckNak_Seq_Num field of the DLLP.
rp_valid_o  out  1  replay request for rp_seq_o.
rp_seq_o  out  SEQ_WIDTH  sequence number to retransmit.
rp_ready_i  in  1  datapath accepts the replay entry.
purge_en_o  out  1  one-cycle pulse: release entries from the retry buffer.
purge_cnt_o  out  RETRY_DEPTH_LG2+1  number of entries released with purge_en_o.
ackd_seq_o  out  SEQ_WIDTH  ACKD_SEQ register.
outstanding_o  out  RETRY_DEPTH_LG2+1  count of unacknowledged TLPs.
replay_num_o  out  2  REPLAY_NUM counter.
retrain_req_o  out  1  one-cycle pulse on REPLAY_NUM rollover.
acknak_err_o  out  1  one-cycle pulse when an Ack/Nak sequence number is out of range.

Behaviour:
- Reset values:
  - next_seq = 0; ackd_seq = all ones (4095 at default); outstanding = 0; timer = 0; REPLAY_NUM = 0; state = NORMAL.
  - All pulse and valid outputs low.
  - tl_ready_o = 1 during the first cycle after reset deassertion.
  - A reset asserted mid-replay aborts the replay and returns every register to these values on the next edge.
- Capacity and TLP acceptance:
  - LIMIT = min(2^RETRY_DEPTH_LG2, 2^(SEQ_WIDTH-1)).
  - tl_ready_o = (state == NORMAL) && (outstanding < LIMIT). This is combinational from registers only.
  - On accept: next_seq increments mod 2^SEQ_WIDTH and outstanding increments by 1.
- Ack/Nak range check:
  - dist = (acknak_seq_i - ackd_seq) mod 2^SEQ_WIDTH.
  - dist == 0: duplicate. No purge and no error.
  - 1 <= dist <= outstanding: valid. ackd_seq <= acknak_seq_i; purge_en_o = 1 and purge_cnt_o = dist on the next cycle; outstanding -= dist.
  - Otherwise: ignored entirely, and acknak_err_o pulses the next cycle.
- Ack with a valid purge:
  - timer <= 0 and REPLAY_NUM <= 0.
- Nak with dist in range, including a duplicate (dist == 0):
  - Applies any purge first.
  - If outstanding is still greater than 0 after the purge, the block enters REPLAY and REPLAY_NUM increments.
  - If outstanding is 0 after the purge, it is treated as a plain Ack.
- Replay timer:
  - Counts only in NORMAL while outstanding > 0; otherwise it holds at 0.
  - When timer == REPLAY_TIMEOUT-1 and no purging Ack arrives that cycle, the block enters REPLAY next cycle and REPLAY_NUM increments.
- REPLAY_NUM rollover:
  - A replay trigger with REPLAY_NUM == REPLAY_NUM_MAX still performs the replay.
  - In that case REPLAY_NUM wraps to 0 and retrain_req_o pulses.
- FSM NORMAL -> REPLAY:
  - rp_ptr <= ackd_seq+1 (post-purge value) and timer <= 0.
  - rp_valid_o is high from the cycle after the trigger.
- FSM in REPLAY:
  - rp_seq_o = rp_ptr. On an rp_valid_o/rp_ready_i handshake, rp_ptr increments.
  - rp_valid_o and rp_seq_o must stay stable until the handshake.
  - Leaves REPLAY when the handshake on rp_seq_o == next_seq-1 completes; the timer then restarts from 0 in NORMAL.
- Ack during REPLAY:
  - The purge is applied.
  - If the new ackd_seq is at or past rp_ptr, rp_ptr <= ackd_seq+1.
  - If outstanding reaches 0, the block exits to NORMAL next cycle with rp_valid_o low.
- Nak or timeout during REPLAY: the purge is applied, and there is no restart and no REPLAY_NUM change.
- Simultaneous events:
  - TLP accept and a purging Ack in the same cycle: outstanding += 1 - dist.
  - Timeout and a purging Ack in the same cycle: the Ack wins and no replay starts.
  - Timeout and a Nak in the same cycle: one replay only, and REPLAY_NUM increments once.
- Wrap-around: next_seq and rp_ptr wrap from 4095 to 0 transparently, and the dist comparison stays correct across the wrap.

Test Plan:
- Reset, then 5 TLP accepts: tl_seq_o = 0..4; outstanding_o = 5; Ack seq 2 -> purge_en_o pulse with purge_cnt_o = 3, ackd_seq_o = 2, outstanding_o = 2.
- 3 TLPs outstanding, no Ack for 711 cycles -> rp_valid_o with rp_seq_o = 0, 1, 2 (rp_ready_i held high), replay_num_o = 1, tl_ready_o = 0 throughout, NORMAL afterwards.
- 4 timeouts with no Ack -> retrain_req_o pulses on the 4th replay trigger, replay_num_o = 0, and the 4th replay still occurs.
- Nak seq 1 with seqs 0..3 outstanding, rp_ready_i toggling -> purge_cnt_o = 2; replays 2 then 3 with the held value stable while stalled.
- Start next_seq = 4094, accept 4 TLPs (4094, 4095, 0, 1); Ack seq 0 -> purge_cnt_o = 3 across the wrap. Ack seq 100 -> acknak_err_o pulses and the state is unchanged.
- Fill to 256 outstanding -> tl_ready_o = 0; same-cycle accept and Ack dist = 1 at outstanding 255 -> outstanding stays 255.

Source files
------------

// File: rtl/dll_replay_ctrl_if.sv
// dll_replay_ctrl_if
//   Groups the TLP ingress handshake, the Ack/Nak DLLP strobe, the replay
//   request handshake and the status/pulse outputs of dll_replay_ctrl.
//   The "master" modport drives the block (ingress logic / bench). The
//   "slave" modport is the controller itself.
//   Signal directions in the names are seen from the controller:
//   *_i are driven by the master, *_o by the controller.
interface dll_replay_ctrl_if #(
    parameter int SEQ_WIDTH       = 12,
    parameter int RETRY_DEPTH_LG2 = 8
);
    logic                       tl_valid_i;
    logic                       tl_ready_o;
    logic [SEQ_WIDTH-1:0]       tl_seq_o;
    logic                       acknak_valid_i;
    logic                       acknak_is_nak_i;
    logic [SEQ_WIDTH-1:0]       acknak_seq_i;
    logic                       rp_valid_o;
    logic [SEQ_WIDTH-1:0]       rp_seq_o;
    logic                       rp_ready_i;
    logic                       purge_en_o;
    logic [RETRY_DEPTH_LG2:0]   purge_cnt_o;
    logic [SEQ_WIDTH-1:0]       ackd_seq_o;
    logic [RETRY_DEPTH_LG2:0]   outstanding_o;
    logic [1:0]                 replay_num_o;
    logic                       retrain_req_o;
    logic                       acknak_err_o;

    modport master (
        output tl_valid_i, acknak_valid_i, acknak_is_nak_i, acknak_seq_i, rp_ready_i,
        input  tl_ready_o, tl_seq_o, rp_valid_o, rp_seq_o, purge_en_o, purge_cnt_o,
               ackd_seq_o, outstanding_o, replay_num_o, retrain_req_o, acknak_err_o
    );

    modport slave (
        input  tl_valid_i, acknak_valid_i, acknak_is_nak_i, acknak_seq_i, rp_ready_i,
        output tl_ready_o, tl_seq_o, rp_valid_o, rp_seq_o, purge_en_o, purge_cnt_o,
               ackd_seq_o, outstanding_o, replay_num_o, retrain_req_o, acknak_err_o
    );
endinterface

// File: rtl/dll_replay_ctrl.sv
// dll_replay_ctrl
//   PCIe Data Link Layer transmit-side sequence number and replay controller.
//   Assigns sequence numbers to new TLPs, tracks unacknowledged TLPs,
//   processes Ack/Nak DLLPs (purging the retry buffer), runs the replay
//   timer, sequences replays and requests retrain on REPLAY_NUM rollover.
// Ports
//   sclk  : clock, all registers update on the rising edge
//   srst  : synchronous active-high reset
//   bus   : dll_replay_ctrl_if.slave
//           tl_valid_i/tl_ready_o/tl_seq_o        TLP ingress
//           acknak_valid_i/_is_nak_i/_seq_i       decoded Ack/Nak DLLP
//           rp_valid_o/rp_seq_o/rp_ready_i        replay request handshake
//           purge_en_o/purge_cnt_o                retry buffer release pulse
//           ackd_seq_o, outstanding_o, replay_num_o  status
//           retrain_req_o, acknak_err_o           one-cycle event pulses
module dll_replay_ctrl #(
    parameter int SEQ_WIDTH       = 12,
    parameter int RETRY_DEPTH_LG2 = 8,
    parameter int TIMER_WIDTH     = 16,
    parameter int REPLAY_TIMEOUT  = 711,
    parameter int REPLAY_NUM_MAX  = 3
) (
    input  logic              sclk,
    input  logic              srst,
    dll_replay_ctrl_if.slave  bus
);

    localparam int SW  = SEQ_WIDTH;
    localparam int RD1 = RETRY_DEPTH_LG2 + 1;
    localparam int TW  = TIMER_WIDTH;
    // Common width used to compare a sequence distance with the outstanding count.
    localparam int CW  = (SW > RD1) ? SW : RD1;
    // Retry buffer capacity, also capped at half the sequence space so that
    // the Ack/Nak distance test stays unambiguous.
    localparam int LIMIT = ((2 ** RETRY_DEPTH_LG2) < (2 ** (SW - 1))) ?
                           (2 ** RETRY_DEPTH_LG2) : (2 ** (SW - 1));

    localparam logic [RD1-1:0] LIMIT_C      = RD1'(LIMIT);
    localparam logic [RD1-1:0] OUT_ZERO_C   = {RD1{1'b0}};
    localparam logic [SW-1:0]  SEQ_ZERO_C   = {SW{1'b0}};
    localparam logic [SW-1:0]  SEQ_ONE_C    = SW'(1);
    localparam logic [SW-1:0]  SEQ_HALF_C   = SW'(2 ** (SW - 1));
    localparam logic [SW-1:0]  SEQ_ONES_C   = {SW{1'b1}};
    localparam logic [TW-1:0]  TIMER_ZERO_C = {TW{1'b0}};
    localparam logic [TW-1:0]  TIMER_ONE_C  = TW'(1);
    localparam logic [TW-1:0]  TIMER_LAST_C = TW'(REPLAY_TIMEOUT - 1);
    localparam logic [1:0]     NUM_MAX_C    = 2'(REPLAY_NUM_MAX);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [SW-1:0]    next_seq_r, next_seq_s;
    logic [SW-1:0]    ackd_seq_r, ackd_seq_s;
    logic [SW-1:0]    rp_ptr_r, rp_ptr_s;
    logic [RD1-1:0]   outstanding_r, outstanding_s;
    logic [TW-1:0]    timer_r, timer_s;
    logic [1:0]       replay_num_r, replay_num_s;
    logic             purge_en_r;
    logic [RD1-1:0]   purge_cnt_r, purge_cnt_s;
    logic             retrain_r, retrain_s;
    logic             err_r;

    logic [SW-1:0]    dist_s;
    logic [RD1-1:0]   out_after_s;
    logic             tl_ready_s, accept_s;
    logic             dup_s, purge_s, err_s;
    logic             ack_reset_s, nak_trig_s, timeout_s, trigger_s;
    logic             handshake_s, last_s, ackd_past_s;

    // Ack/Nak classification: distance from ACKD_SEQ decides duplicate, valid or bogus.
    assign dist_s      = bus.acknak_seq_i - ackd_seq_r;
    assign dup_s       = bus.acknak_valid_i && (dist_s == SEQ_ZERO_C);
    assign purge_s     = bus.acknak_valid_i && (dist_s != SEQ_ZERO_C) &&
                         (CW'(dist_s) <= CW'(outstanding_r));
    assign err_s       = bus.acknak_valid_i && !purge_s && !dup_s;
    assign out_after_s = RD1'(CW'(outstanding_r) - (purge_s ? CW'(dist_s) : {CW{1'b0}}));
    assign ackd_seq_s  = purge_s ? bus.acknak_seq_i : ackd_seq_r;

    // TLP acceptance depends only on registered state.
    assign tl_ready_s  = (state_r == ST_NORMAL) && (outstanding_r < LIMIT_C);
    assign accept_s    = bus.tl_valid_i && tl_ready_s;

    // A Nak that leaves nothing outstanding behaves like an Ack.
    assign ack_reset_s = purge_s && (!bus.acknak_is_nak_i || (out_after_s == OUT_ZERO_C));
    assign nak_trig_s  = bus.acknak_valid_i && bus.acknak_is_nak_i && (purge_s || dup_s) &&
                         (out_after_s != OUT_ZERO_C);
    // A purging Ack in the expiry cycle suppresses the timeout.
    assign timeout_s   = (timer_r == TIMER_LAST_C) && !ack_reset_s;
    // Nak and timeout together still give a single replay trigger.
    assign trigger_s   = (state_r == ST_NORMAL) && (nak_trig_s || timeout_s);

    assign handshake_s = (state_r == ST_REPLAY) && bus.rp_ready_i;
    assign last_s      = (rp_ptr_r == (next_seq_r - SEQ_ONE_C));
    // Modular "ackd_seq at or past rp_ptr": forward distance below half the space.
    assign ackd_past_s = purge_s && ((ackd_seq_s - rp_ptr_r) < SEQ_HALF_C);

    assign next_seq_s    = next_seq_r + {{(SW-1){1'b0}}, accept_s};
    assign outstanding_s = out_after_s + {{(RD1-1){1'b0}}, accept_s};
    assign purge_cnt_s   = purge_s ? RD1'(dist_s) : OUT_ZERO_C;

    // Next state, replay pointer, replay timer and REPLAY_NUM.
    always_comb begin
        state_s      = state_r;
        rp_ptr_s     = rp_ptr_r;
        timer_s      = timer_r;
        replay_num_s = replay_num_r;
        retrain_s    = 1'b0;
        case (state_r)
            ST_NORMAL: begin
                if (trigger_s) begin
                    state_s  = ST_REPLAY;
                    rp_ptr_s = ackd_seq_s + SEQ_ONE_C;
                    timer_s  = TIMER_ZERO_C;
                    if (replay_num_r == NUM_MAX_C) begin
                        replay_num_s = 2'd0;
                        retrain_s    = 1'b1;
                    end else begin
                        replay_num_s = replay_num_r + 2'd1;
                        retrain_s    = 1'b0;
                    end
                end else if (ack_reset_s) begin
                    timer_s      = TIMER_ZERO_C;
                    replay_num_s = 2'd0;
                end else if (outstanding_r != OUT_ZERO_C) begin
                    timer_s = timer_r + TIMER_ONE_C;
                end else begin
                    timer_s = TIMER_ZERO_C;
                end
            end
            ST_REPLAY: begin
                // The timer is parked during a replay; Nak/timeout cannot restart it.
                timer_s = TIMER_ZERO_C;
                if (purge_s && !bus.acknak_is_nak_i) begin
                    replay_num_s = 2'd0;
                end else begin
                    replay_num_s = replay_num_r;
                end
                if (out_after_s == OUT_ZERO_C) begin
                    state_s = ST_NORMAL;
                end else if (handshake_s && last_s) begin
                    state_s = ST_NORMAL;
                end else if (ackd_past_s) begin
                    rp_ptr_s = ackd_seq_s + SEQ_ONE_C;
                end else if (handshake_s) begin
                    rp_ptr_s = rp_ptr_r + SEQ_ONE_C;
                end else begin
                    rp_ptr_s = rp_ptr_r;
                end
            end
            default: begin
                state_s      = ST_NORMAL;
                rp_ptr_s     = rp_ptr_r;
                timer_s      = TIMER_ZERO_C;
                replay_num_s = replay_num_r;
            end
        endcase
    end

    // State and output registers; srst returns everything to its idle value.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_r       <= ST_NORMAL;
            next_seq_r    <= SEQ_ZERO_C;
            ackd_seq_r    <= SEQ_ONES_C;
            rp_ptr_r      <= SEQ_ZERO_C;
            outstanding_r <= OUT_ZERO_C;
            timer_r       <= TIMER_ZERO_C;
            replay_num_r  <= 2'd0;
            purge_en_r    <= 1'b0;
            purge_cnt_r   <= OUT_ZERO_C;
            retrain_r     <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            next_seq_r    <= next_seq_s;
            ackd_seq_r    <= ackd_seq_s;
            rp_ptr_r      <= rp_ptr_s;
            outstanding_r <= outstanding_s;
            timer_r       <= timer_s;
            replay_num_r  <= replay_num_s;
            purge_en_r    <= purge_s;
            purge_cnt_r   <= purge_cnt_s;
            retrain_r     <= retrain_s;
            err_r         <= err_s;
        end
    end

    assign bus.tl_ready_o    = tl_ready_s;
    assign bus.tl_seq_o      = next_seq_r;
    assign bus.rp_valid_o    = (state_r == ST_REPLAY);
    assign bus.rp_seq_o      = rp_ptr_r;
    assign bus.purge_en_o    = purge_en_r;
    assign bus.purge_cnt_o   = purge_cnt_r;
    assign bus.ackd_seq_o    = ackd_seq_r;
    assign bus.outstanding_o = outstanding_r;
    assign bus.replay_num_o  = replay_num_r;
    assign bus.retrain_req_o = retrain_r;
    assign bus.acknak_err_o  = err_r;

endmodule

// File: tb/tb_dll_replay_ctrl.sv
// tb_dll_replay_ctrl
//   Directed, table-driven bench for dll_replay_ctrl at default parameters,
//   plus hand-written sequences for timeout replays, REPLAY_NUM rollover,
//   Nak with a stalled replay port, reset mid-replay, sequence wrap and a
//   full retry buffer.
module tb_dll_replay_ctrl;

    logic sclk = 1'b0;
    logic srst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    dll_replay_ctrl_if #(.SEQ_WIDTH(12), .RETRY_DEPTH_LG2(8)) bus ();

    dll_replay_ctrl #(
        .SEQ_WIDTH(12), .RETRY_DEPTH_LG2(8), .TIMER_WIDTH(16),
        .REPLAY_TIMEOUT(711), .REPLAY_NUM_MAX(3)
    ) dut (
        .sclk (sclk),
        .srst (srst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        bit tl_v; bit ak_v; bit nak; int seq;
        int e_rdy; int e_tseq; int e_pen; int e_pcnt; int e_ackd; int e_out; int e_err; int e_rpv;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tl_valid_i      = 1'b0;
        bus.acknak_valid_i  = 1'b0;
        bus.acknak_is_nak_i = 1'b0;
        bus.acknak_seq_i    = 12'd0;
        bus.rp_ready_i      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        srst = 1'b1;
        step();
        step();
        srst = 1'b0;
    endtask

    task automatic ack(input bit nak, input int seq);
        bus.acknak_valid_i  = 1'b1;
        bus.acknak_is_nak_i = nak;
        bus.acknak_seq_i    = 12'(seq);
        step();
        bus.acknak_valid_i  = 1'b0;
        bus.acknak_is_nak_i = 1'b0;
    endtask

    // Wait (bounded) for rp_valid_o; check delay, retrain pulse and REPLAY_NUM.
    task automatic wait_rp(input int exp_cnt, input int exp_rt, input int exp_num, input string tag);
        int cnt = 0;
        while (!bus.rp_valid_o && cnt < 2000) begin
            step();
            cnt++;
        end
        check({tag, "_delay"}, cnt, exp_cnt);
        check({tag, "_retrain"}, {31'd0, bus.retrain_req_o}, exp_rt);
        check({tag, "_num"}, {30'd0, bus.replay_num_o}, exp_num);
    endtask

    // Follow a replay with rp_ready_i high; check each replayed seq.
    task automatic run_replay(input int first, input int n, input string tag);
        int k = 0;
        while (bus.rp_valid_o && k < 50) begin
            check({tag, "_seq"}, {20'd0, bus.rp_seq_o}, (first + k) % 4096);
            check({tag, "_tlrdy"}, {31'd0, bus.tl_ready_o}, 0);
            step();
            k++;
            if (k == 1) check({tag, "_retrain_1cyc"}, {31'd0, bus.retrain_req_o}, 0);
        end
        check({tag, "_len"}, k, n);
        check({tag, "_tlrdy_after"}, {31'd0, bus.tl_ready_o}, 1);
    endtask

    initial begin
        // {tl_v, ak_v, nak, seq | rdy, tl_seq, purge_en, purge_cnt, ackd, outstanding, err, rp_valid}
        vecs[0]  = '{0, 0, 0,   0,  1, 0, 0, 0, 4095, 0, 0, 0};
        vecs[1]  = '{1, 0, 0,   0,  1, 1, 0, 0, 4095, 1, 0, 0};
        vecs[2]  = '{1, 0, 0,   0,  1, 2, 0, 0, 4095, 2, 0, 0};
        vecs[3]  = '{1, 0, 0,   0,  1, 3, 0, 0, 4095, 3, 0, 0};
        vecs[4]  = '{1, 0, 0,   0,  1, 4, 0, 0, 4095, 4, 0, 0};
        vecs[5]  = '{1, 0, 0,   0,  1, 5, 0, 0, 4095, 5, 0, 0};
        vecs[6]  = '{0, 1, 0,   2,  1, 5, 1, 3, 2,    2, 0, 0};
        vecs[7]  = '{0, 1, 0,   2,  1, 5, 0, 0, 2,    2, 0, 0};
        vecs[8]  = '{0, 1, 0, 100,  1, 5, 0, 0, 2,    2, 1, 0};
        vecs[9]  = '{1, 1, 0,   3,  1, 6, 1, 1, 3,    2, 0, 0};
        vecs[10] = '{0, 1, 0,   5,  1, 6, 1, 2, 5,    0, 0, 0};
        vecs[11] = '{0, 1, 0,   6,  1, 6, 0, 0, 5,    0, 1, 0};
        vecs[12] = '{0, 1, 1,   5,  1, 6, 0, 0, 5,    0, 0, 0};
        vecs[13] = '{0, 0, 0,   0,  1, 6, 0, 0, 5,    0, 0, 0};

        do_reset();
        check("rst_tl_ready", {31'd0, bus.tl_ready_o}, 1);
        check("rst_tl_seq", {20'd0, bus.tl_seq_o}, 0);
        check("rst_ackd", {20'd0, bus.ackd_seq_o}, 4095);
        check("rst_out", {23'd0, bus.outstanding_o}, 0);
        check("rst_rp_valid", {31'd0, bus.rp_valid_o}, 0);
        check("rst_purge_en", {31'd0, bus.purge_en_o}, 0);
        check("rst_num", {30'd0, bus.replay_num_o}, 0);

        // Table: apply inputs, one edge, compare the post-edge outputs.
        for (int i = 0; i < 14; i++) begin
            bus.tl_valid_i      = vecs[i].tl_v;
            bus.acknak_valid_i  = vecs[i].ak_v;
            bus.acknak_is_nak_i = vecs[i].nak;
            bus.acknak_seq_i    = 12'(vecs[i].seq);
            step();
            check($sformatf("v%0d_tl_ready", i), {31'd0, bus.tl_ready_o}, vecs[i].e_rdy);
            check($sformatf("v%0d_tl_seq", i), {20'd0, bus.tl_seq_o}, vecs[i].e_tseq);
            check($sformatf("v%0d_purge_en", i), {31'd0, bus.purge_en_o}, vecs[i].e_pen);
            check($sformatf("v%0d_purge_cnt", i), {23'd0, bus.purge_cnt_o}, vecs[i].e_pcnt);
            check($sformatf("v%0d_ackd", i), {20'd0, bus.ackd_seq_o}, vecs[i].e_ackd);
            check($sformatf("v%0d_out", i), {23'd0, bus.outstanding_o}, vecs[i].e_out);
            check($sformatf("v%0d_err", i), {31'd0, bus.acknak_err_o}, vecs[i].e_err);
            check($sformatf("v%0d_rp_valid", i), {31'd0, bus.rp_valid_o}, vecs[i].e_rpv);
        end
        idle_inputs();

        // Timeout replays of seqs 0..2; the 4th trigger rolls REPLAY_NUM and requests retrain.
        do_reset();
        bus.tl_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("to_tl_seq", {20'd0, bus.tl_seq_o}, i);
            step();
        end
        bus.tl_valid_i = 1'b0;
        wait_rp(709, 0, 1, "to1");
        run_replay(0, 3, "rp1");
        wait_rp(711, 0, 2, "to2");
        run_replay(0, 3, "rp2");
        wait_rp(711, 0, 3, "to3");
        run_replay(0, 3, "rp3");
        wait_rp(711, 1, 0, "to4");
        run_replay(0, 3, "rp4");
        check("to_out_after", {23'd0, bus.outstanding_o}, 3);

        // Nak seq 1 with 0..3 outstanding; replay port stalls every other cycle.
        do_reset();
        bus.tl_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.tl_valid_i = 1'b0;
        ack(1'b1, 1);
        check("nak_purge_en", {31'd0, bus.purge_en_o}, 1);
        check("nak_purge_cnt", {23'd0, bus.purge_cnt_o}, 2);
        check("nak_rp_valid", {31'd0, bus.rp_valid_o}, 1);
        check("nak_rp_seq0", {20'd0, bus.rp_seq_o}, 2);
        check("nak_num", {30'd0, bus.replay_num_o}, 1);
        bus.rp_ready_i = 1'b0; step();
        check("nak_stall_valid", {31'd0, bus.rp_valid_o}, 1);
        check("nak_stall_seq0", {20'd0, bus.rp_seq_o}, 2);
        bus.rp_ready_i = 1'b1; step();
        check("nak_rp_seq1", {20'd0, bus.rp_seq_o}, 3);
        bus.rp_ready_i = 1'b0; step();
        check("nak_stall_seq1", {20'd0, bus.rp_seq_o}, 3);
        check("nak_stall_valid1", {31'd0, bus.rp_valid_o}, 1);
        bus.rp_ready_i = 1'b1; step();
        check("nak_done_valid", {31'd0, bus.rp_valid_o}, 0);
        check("nak_done_tlrdy", {31'd0, bus.tl_ready_o}, 1);
        check("nak_done_out", {23'd0, bus.outstanding_o}, 2);

        // Reset while a replay is pending aborts it.
        do_reset();
        bus.tl_valid_i = 1'b1;
        step(); step();
        bus.tl_valid_i = 1'b0;
        bus.rp_ready_i = 1'b0;
        ack(1'b1, 0);
        check("mid_rp_valid", {31'd0, bus.rp_valid_o}, 1);
        srst = 1'b1; step(); srst = 1'b0;
        check("mid_rst_valid", {31'd0, bus.rp_valid_o}, 0);
        check("mid_rst_out", {23'd0, bus.outstanding_o}, 0);
        check("mid_rst_ackd", {20'd0, bus.ackd_seq_o}, 4095);
        check("mid_rst_seq", {20'd0, bus.tl_seq_o}, 0);
        check("mid_rst_num", {30'd0, bus.replay_num_o}, 0);
        check("mid_rst_tlrdy", {31'd0, bus.tl_ready_o}, 1);
        bus.rp_ready_i = 1'b1;

        // Walk next_seq to 4094 with accept/Ack pairs, then purge across the wrap.
        do_reset();
        for (int i = 0; i < 4094; i++) begin
            bus.tl_valid_i = 1'b1; step();
            bus.tl_valid_i = 1'b0;
            ack(1'b0, i);
        end
        check("wr_tl_seq", {20'd0, bus.tl_seq_o}, 4094);
        check("wr_ackd", {20'd0, bus.ackd_seq_o}, 4093);
        bus.tl_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wr_acc_seq", {20'd0, bus.tl_seq_o}, (4094 + i) % 4096);
            step();
        end
        bus.tl_valid_i = 1'b0;
        check("wr_out4", {23'd0, bus.outstanding_o}, 4);
        ack(1'b0, 0);
        check("wr_purge_en", {31'd0, bus.purge_en_o}, 1);
        check("wr_purge_cnt", {23'd0, bus.purge_cnt_o}, 3);
        check("wr_ackd0", {20'd0, bus.ackd_seq_o}, 0);
        check("wr_out1", {23'd0, bus.outstanding_o}, 1);
        ack(1'b0, 100);
        check("wr_err", {31'd0, bus.acknak_err_o}, 1);
        check("wr_err_nopurge", {31'd0, bus.purge_en_o}, 0);
        check("wr_err_ackd", {20'd0, bus.ackd_seq_o}, 0);
        check("wr_err_out", {23'd0, bus.outstanding_o}, 1);
        step();
        check("wr_err_1cyc", {31'd0, bus.acknak_err_o}, 0);

        // Fill the retry buffer; same-cycle accept and Ack at 255 keeps 255.
        do_reset();
        bus.tl_valid_i = 1'b1;
        for (int i = 0; i < 255; i++) step();
        check("fill_out255", {23'd0, bus.outstanding_o}, 255);
        check("fill_rdy255", {31'd0, bus.tl_ready_o}, 1);
        bus.acknak_valid_i = 1'b1;
        bus.acknak_seq_i   = 12'd0;
        step();
        bus.acknak_valid_i = 1'b0;
        check("fill_both_out", {23'd0, bus.outstanding_o}, 255);
        check("fill_both_cnt", {23'd0, bus.purge_cnt_o}, 1);
        check("fill_both_seq", {20'd0, bus.tl_seq_o}, 256);
        step();
        check("fill_out256", {23'd0, bus.outstanding_o}, 256);
        check("fill_rdy256", {31'd0, bus.tl_ready_o}, 0);
        step();
        check("fill_hold_out", {23'd0, bus.outstanding_o}, 256);
        check("fill_hold_seq", {20'd0, bus.tl_seq_o}, 257);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
